// File: rtl/hit_detector_if.sv
// Signal bundle between the VGA pixel pipeline and hit_detector.
// master drives per-pixel draw requests and frame timing; slave returns hit pulses and grace status.
interface hit_detector_if #(
    parameter int NUM_BUBBLES = 8
);
    logic                   startOfFrame;
    logic                   charEnable;
    logic                   charDR;
    logic [NUM_BUBBLES-1:0] bubbleDR;
    logic                   ropeDR;
    logic                   charHit;
    logic [NUM_BUBBLES-1:0] bubbleHit;
    logic                   ropeHit;
    logic                   inGrace;
    logic                   charVisible;

    modport master (
        output startOfFrame, charEnable, charDR, bubbleDR, ropeDR,
        input  charHit, bubbleHit, ropeHit, inGrace, charVisible
    );

    modport slave (
        input  startOfFrame, charEnable, charDR, bubbleDR, ropeDR,
        output charHit, bubbleHit, ropeHit, inGrace, charVisible
    );
endinterface

// File: rtl/hit_detector.sv
// Frame-based character/bubble/rope collision detector with post-hit grace period.
// Optional grace blink of charVisible is built when GRACE_BLINK_EN is defined.
module hit_detector #(
    parameter int NUM_BUBBLES  = 8,
    parameter int GRACE_FRAMES = 60,
    parameter int BLINK_FRAMES = 4
) (
    input  logic          clk,
    input  logic          resetN,
    hit_detector_if.slave hd
);
    localparam int GW = $clog2(GRACE_FRAMES + 1);
    localparam logic [GW-1:0] GRACE_RELOAD = GW'(GRACE_FRAMES);

    if (NUM_BUBBLES < 1 || NUM_BUBBLES > 16 || GRACE_FRAMES < 1 || GRACE_FRAMES > 255 ||
        BLINK_FRAMES < 1 || BLINK_FRAMES > GRACE_FRAMES) begin : g_bad_params
        $error("hit_detector: parameter out of range");
    end

    logic                   char_acc_q, char_acc_d;
    logic [NUM_BUBBLES-1:0] bub_acc_q, bub_acc_d;
    logic                   char_hit_q, char_hit_d;
    logic                   rope_hit_q, rope_hit_d;
    logic [NUM_BUBBLES-1:0] bubble_hit_q, bubble_hit_d;
    logic [GW-1:0]          grace_q, grace_d;
    logic                   char_en_q, char_en_d;
    logic                   char_overlap;
    logic [NUM_BUBBLES-1:0] rope_overlap;

    always_comb begin
        char_overlap = hd.charDR & (|hd.bubbleDR);
        rope_overlap = hd.bubbleDR & {NUM_BUBBLES{hd.ropeDR}};
        char_en_d    = hd.charEnable;
        char_hit_d   = 1'b0;
        rope_hit_d   = 1'b0;
        bubble_hit_d = '0;
        if (hd.startOfFrame) begin
            char_hit_d   = char_acc_q & hd.charEnable & (grace_q == '0);
            rope_hit_d   = |bub_acc_q;
            // Isolate the lowest set bit: one pop per rope per frame.
            bubble_hit_d = bub_acc_q & (~bub_acc_q + NUM_BUBBLES'(1));
            // The boundary pixel already belongs to the new frame.
            char_acc_d   = hd.charEnable & char_overlap;
            bub_acc_d    = rope_overlap;
        end else begin
            char_acc_d   = hd.charEnable & (char_acc_q | char_overlap);
            bub_acc_d    = bub_acc_q | rope_overlap;
        end

        grace_d = grace_q;
        if (hd.startOfFrame && (grace_q != '0)) begin
            grace_d = grace_q - GW'(1);
        end
        if (char_hit_d || (hd.charEnable && !char_en_q)) begin
            grace_d = GRACE_RELOAD;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            char_acc_q   <= 1'b0;
            bub_acc_q    <= '0;
            char_hit_q   <= 1'b0;
            rope_hit_q   <= 1'b0;
            bubble_hit_q <= '0;
            grace_q      <= GRACE_RELOAD;
            char_en_q    <= 1'b0;
        end else begin
            char_acc_q   <= char_acc_d;
            bub_acc_q    <= bub_acc_d;
            char_hit_q   <= char_hit_d;
            rope_hit_q   <= rope_hit_d;
            bubble_hit_q <= bubble_hit_d;
            grace_q      <= grace_d;
            char_en_q    <= char_en_d;
        end
    end

    assign hd.charHit   = char_hit_q;
    assign hd.ropeHit   = rope_hit_q;
    assign hd.bubbleHit = bubble_hit_q;
    assign hd.inGrace   = (grace_q != '0);

`ifdef GRACE_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          vis_q, vis_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        vis_d       = vis_q;
        if (hd.startOfFrame && (grace_q != '0)) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                vis_d       = ~vis_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        if (grace_d == '0) begin
            vis_d       = 1'b1;
            blink_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt_q <= '0;
            vis_q       <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            vis_q       <= vis_d;
        end
    end

    assign hd.charVisible = vis_q;
`else
    assign hd.charVisible = 1'b1;
`endif
endmodule

// File: tb/tb_hit_detector.sv
// Self-checking bench for hit_detector: directed scenarios plus randomized frames against a frame-level model.
// Define GRACE_BLINK_EN for both RTL and bench to cover the blink variant.
module tb_hit_detector;
    localparam int NB = 8;
    localparam int GF = 60;
    localparam int BF = 4;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hit_detector_if #(.NUM_BUBBLES(NB)) hd ();

    hit_detector #(.NUM_BUBBLES(NB), .GRACE_FRAMES(GF), .BLINK_FRAMES(BF)) dut (
        .clk    (clk),
        .resetN (resetN),
        .hd     (hd)
    );

    always #5 clk = ~clk;

    // Reference model state, frame-level view of the rules.
    int          m_grace;
    bit          m_char_acc;
    bit [NB-1:0] m_bub_acc;
    bit          m_prev_en;
    int          m_blink_frames;
    bit          e_char_hit;
    bit          e_rope_hit;
    bit [NB-1:0] e_bub_hit;
    bit          e_vis;

    function automatic bit [NB-1:0] lowest(input bit [NB-1:0] v);
        bit [NB-1:0] r;
        bit          found;
        r = '0;
        found = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (v[i] && !found) begin
                r[i] = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_grace = GF;
        m_char_acc = 1'b0;
        m_bub_acc = '0;
        m_prev_en = 1'b0;
        m_blink_frames = 0;
        e_char_hit = 1'b0;
        e_rope_hit = 1'b0;
        e_bub_hit = '0;
        e_vis = 1'b1;
    endtask

    task automatic step(input bit sof, input bit en, input bit cdr, input bit [NB-1:0] bdr, input bit rdr);
        bit ov;
`ifdef GRACE_BLINK_EN
        int g_old;
        g_old = m_grace;
`endif
        hd.startOfFrame = sof;
        hd.charEnable = en;
        hd.charDR = cdr;
        hd.bubbleDR = bdr;
        hd.ropeDR = rdr;
        ov = cdr && (bdr != '0);
        if (sof) begin
            e_char_hit = m_char_acc && en && (m_grace == 0);
            e_rope_hit = (m_bub_acc != '0);
            e_bub_hit = lowest(m_bub_acc);
            m_char_acc = en && ov;
            m_bub_acc = rdr ? bdr : '0;
            if (m_grace > 0) m_grace = m_grace - 1;
        end else begin
            e_char_hit = 1'b0;
            e_rope_hit = 1'b0;
            e_bub_hit = '0;
            m_char_acc = en && (m_char_acc || ov);
            if (rdr) m_bub_acc = m_bub_acc | bdr;
        end
        if (e_char_hit || (en && !m_prev_en)) m_grace = GF;
        m_prev_en = en;
`ifdef GRACE_BLINK_EN
        if (sof && g_old > 0) begin
            m_blink_frames++;
            if (m_blink_frames == BF) begin
                e_vis = !e_vis;
                m_blink_frames = 0;
            end
        end
        if (m_grace == 0) begin
            e_vis = 1'b1;
            m_blink_frames = 0;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        step_inputs_idle();
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic step_inputs_idle();
        hd.startOfFrame = 1'b0;
        hd.charEnable = 1'b0;
        hd.charDR = 1'b0;
        hd.bubbleDR = '0;
        hd.ropeDR = 1'b0;
    endtask

    task automatic run_frames(input int n, input bit en);
        for (int f = 0; f < n; f++) begin
            step(1'b1, en, 1'b0, '0, 1'b0);
            repeat (3) step(1'b0, en, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_reset();
        step_inputs_idle();
        #2 resetN = 1'b0;
        #1;
        checks++; if (hd.charHit !== 1'b0) begin failures++; $display("FAIL reset_charHit: got %b want 0", hd.charHit); end
        checks++; if (hd.ropeHit !== 1'b0) begin failures++; $display("FAIL reset_ropeHit: got %b want 0", hd.ropeHit); end
        checks++; if (hd.bubbleHit !== 8'h00) begin failures++; $display("FAIL reset_bubbleHit: got %h want 00", hd.bubbleHit); end
        checks++; if (hd.inGrace !== 1'b1) begin failures++; $display("FAIL reset_inGrace: got %b want 1", hd.inGrace); end
        checks++; if (hd.charVisible !== 1'b1) begin failures++; $display("FAIL reset_charVisible: got %b want 1", hd.charVisible); end
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic test_char_hit();
        do_reset();
        run_frames(62, 1'b1);
        checks++; if (hd.inGrace !== 1'b0) begin failures++; $display("FAIL grace_expired: inGrace=%b want 0", hd.inGrace); end
        repeat (3) step(1'b0, 1'b1, 1'b1, 8'b0000_0100, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.charHit !== 1'b1) begin failures++; $display("FAIL char_hit_pulse: charHit=%b want 1", hd.charHit); end
        checks++; if (hd.inGrace !== 1'b1) begin failures++; $display("FAIL char_hit_grace: inGrace=%b want 1", hd.inGrace); end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.charHit !== 1'b0) begin failures++; $display("FAIL char_hit_one_cycle: charHit=%b want 0", hd.charHit); end
    endtask

    task automatic test_grace();
        bit [NB-1:0] b;
        for (int k = 1; k <= GF; k++) begin
            b = '0;
            b[k % NB] = 1'b1;
            step(1'b0, 1'b1, 1'b1, b, 1'b0);
            step(1'b1, 1'b1, 1'b0, '0, 1'b0);
            checks++; if (hd.charHit !== 1'b0) begin failures++; $display("FAIL grace_suppress frame %0d: charHit=%b want 0", k, hd.charHit); end
        end
        checks++; if (hd.inGrace !== 1'b0) begin failures++; $display("FAIL grace_end: inGrace=%b want 0", hd.inGrace); end
        step(1'b0, 1'b1, 1'b1, 8'b1000_0000, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.charHit !== 1'b1) begin failures++; $display("FAIL grace_after_hit: charHit=%b want 1", hd.charHit); end
    endtask

    task automatic test_rope();
        step(1'b0, 1'b1, 1'b0, 8'b0010_0000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'b0000_0010, 1'b1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.bubbleHit !== 8'b0000_0010) begin failures++; $display("FAIL rope_lowest: bubbleHit=%b want 00000010", hd.bubbleHit); end
        checks++; if (hd.ropeHit !== 1'b1) begin failures++; $display("FAIL rope_hit: ropeHit=%b want 1", hd.ropeHit); end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.bubbleHit !== 8'b0 || hd.ropeHit !== 1'b0) begin failures++; $display("FAIL rope_one_cycle: bubbleHit=%b ropeHit=%b want 0/0", hd.bubbleHit, hd.ropeHit); end
    endtask

    task automatic test_sof_coincident();
        step(1'b1, 1'b1, 1'b0, 8'b0000_1000, 1'b1);
        checks++; if (hd.ropeHit !== 1'b0) begin failures++; $display("FAIL sof_coincident_now: ropeHit=%b want 0", hd.ropeHit); end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.ropeHit !== 1'b1) begin failures++; $display("FAIL sof_coincident_next: ropeHit=%b want 1", hd.ropeHit); end
        checks++; if (hd.bubbleHit !== 8'b0000_1000) begin failures++; $display("FAIL sof_coincident_bub: bubbleHit=%b want 00001000", hd.bubbleHit); end
    endtask

    task automatic test_enable_toggle();
        do_reset();
        run_frames(62, 1'b1);
        for (int f = 0; f < 5; f++) begin
            repeat (2) step(1'b0, 1'b0, 1'b1, 8'hff, 1'b0);
            step(1'b1, 1'b0, 1'b1, 8'hff, 1'b0);
            checks++; if (hd.charHit !== 1'b0) begin failures++; $display("FAIL enable_low frame %0d: charHit=%b want 0", f, hd.charHit); end
        end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.inGrace !== 1'b1) begin failures++; $display("FAIL respawn_grace: inGrace=%b want 1", hd.inGrace); end
        for (int k = 1; k <= GF; k++) begin
            step(1'b1, 1'b1, 1'b0, '0, 1'b0);
            repeat (2) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
            checks++; if (hd.inGrace !== (k < GF)) begin failures++; $display("FAIL respawn_count frame %0d: inGrace=%b want %b", k, hd.inGrace, k < GF); end
        end
        step(1'b0, 1'b1, 1'b0, 8'b0000_0001, 1'b1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.ropeHit !== 1'b1) begin failures++; $display("FAIL pre_reset_rope: ropeHit=%b want 1", hd.ropeHit); end
        #2 resetN = 1'b0;
        #1;
        checks++; if (hd.ropeHit !== 1'b0 || hd.bubbleHit !== 8'h00 || hd.charHit !== 1'b0) begin failures++; $display("FAIL async_reset_pulses: rope=%b bub=%h char=%b want 0", hd.ropeHit, hd.bubbleHit, hd.charHit); end
        checks++; if (hd.charVisible !== 1'b1 || hd.inGrace !== 1'b1) begin failures++; $display("FAIL async_reset_state: vis=%b grace=%b want 1/1", hd.charVisible, hd.inGrace); end
        step_inputs_idle();
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic test_no_sof();
        do_reset();
        run_frames(62, 1'b1);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'hff, 1'b1);
            checks++; if (hd.charHit !== 1'b0 || hd.ropeHit !== 1'b0 || hd.bubbleHit !== 8'h00) begin failures++; $display("FAIL no_sof cycle %0d: char=%b rope=%b bub=%h want 0", i, hd.charHit, hd.ropeHit, hd.bubbleHit); end
        end
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checks++; if (hd.charHit !== 1'b1 || hd.ropeHit !== 1'b1 || hd.bubbleHit !== 8'b0000_0001) begin failures++; $display("FAIL no_sof_release: char=%b rope=%b bub=%b want 1/1/00000001", hd.charHit, hd.ropeHit, hd.bubbleHit); end
    endtask

    task automatic test_blink();
        bit exp_vis;
        do_reset();
        for (int k = 1; k <= GF + 10; k++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b0);
            step(1'b0, 1'b0, 1'b0, '0, 1'b0);
`ifdef GRACE_BLINK_EN
            exp_vis = (k >= GF) ? 1'b1 : (((k / BF) % 2) == 0);
`else
            exp_vis = 1'b1;
`endif
            checks++; if (hd.charVisible !== exp_vis) begin failures++; $display("FAIL blink frame %0d: charVisible=%b want %b", k, hd.charVisible, exp_vis); end
        end
    endtask

    task automatic test_random();
        bit en;
        bit [NB-1:0] b;
        int len;
        do_reset();
        en = 1'b1;
        for (int f = 0; f < 600; f++) begin
            len = $urandom_range(2, 10);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 399) == 0) en = !en;
                b = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
                step(c == 0, en, $urandom_range(0, 3) == 0, b, $urandom_range(0, 4) == 0);
                checks++; if (hd.charHit !== e_char_hit) begin failures++; $display("FAIL rand_charHit f%0d c%0d: got %b want %b", f, c, hd.charHit, e_char_hit); end
                checks++; if (hd.ropeHit !== e_rope_hit) begin failures++; $display("FAIL rand_ropeHit f%0d c%0d: got %b want %b", f, c, hd.ropeHit, e_rope_hit); end
                checks++; if (hd.bubbleHit !== e_bub_hit) begin failures++; $display("FAIL rand_bubbleHit f%0d c%0d: got %b want %b", f, c, hd.bubbleHit, e_bub_hit); end
                checks++; if (hd.inGrace !== (m_grace != 0)) begin failures++; $display("FAIL rand_inGrace f%0d c%0d: got %b want %b", f, c, hd.inGrace, m_grace != 0); end
                checks++; if (hd.charVisible !== e_vis) begin failures++; $display("FAIL rand_charVisible f%0d c%0d: got %b want %b", f, c, hd.charVisible, e_vis); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_char_hit();
        test_grace();
        test_rope();
        test_sof_coincident();
        test_enable_toggle();
        test_no_sof();
        test_blink();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
